// File: rtl/decoder_scan_if.sv
// Host <-> sequencer bundle: scan control in, 3-bit decoder code and status out.
interface decoder_scan_if;
    logic       start;
    logic       stop;
    logic       one_shot;
    logic [7:0] mask;
    logic       A2;
    logic       A1;
    logic       A0;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, stop, one_shot, mask,
        input  A2, A1, A0, valid, busy, done, err
    );

    modport slave (
        input  start, stop, one_shot, mask,
        output A2, A1, A0, valid, busy, done, err
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Walks enabled 3-to-8 decoder channels in ascending order, holding each code for
// DWELL cycles with valid high, and a dead SEEK cycle between channels.
//
// state | meaning
// IDLE  | waiting for start; code holds its last value
// SEEK  | valid=0, tests mask_q[ptr] once per cycle
// HOLD  | valid=1, code stable while the dwell counter runs down
// DONE  | one-shot pass complete; done pulses on the way back to IDLE
module decoder_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_scan_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEEK, S_HOLD, S_DONE} state_t;

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       mask_q, mask_d;
    logic             os_q, os_d;
    logic [2:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        os_d    = os_q;
        code_d  = code_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // stop beats every other transition; the code is left where it was
        if (state_q != S_IDLE && bus.stop) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.mask != 8'h00) begin
                            state_d = S_SEEK;
                            mask_d  = bus.mask;
                            os_d    = bus.one_shot;
                            ptr_d   = 3'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_SEEK: begin
                    if (mask_q[ptr_q]) begin
                        state_d = S_HOLD;
                        code_d  = ptr_q;
                        cnt_d   = DWELL_M1;
                        valid_d = 1'b1;
                    end else if (ptr_q == 3'd7 && os_q) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        if (ptr_q == 3'd7 && os_q) begin
                            state_d = S_DONE;
                        end else begin
                            ptr_d   = ptr_q + 3'd1;
                            state_d = S_SEEK;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
            mask_q  <= 8'h00;
            os_q    <= 1'b0;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            os_q    <= os_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign {bus.A2, bus.A1, bus.A0} = code_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: a per-cycle expected-output list is built from
// the channel-walk rules and compared with the DUT and a behavioural 3-to-8 decoder.
module tb_decoder_scan_sequencer;
    localparam int DWELL = 4;

    typedef struct packed {
        logic [2:0] code;
        logic       valid;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [2:0] model_code = 3'd0;

    decoder_scan_if sif ();

    decoder_scan_sequencer #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] c, input logic v, input logic b,
                                input logic d, input logic e);
        exp_t x;
        x.code = c; x.valid = v; x.busy = b; x.done = d; x.err = e;
        return x;
    endfunction

    function automatic logic [31:0] observed();
        exp_t o;
        o = mk({sif.A2, sif.A1, sif.A0}, sif.valid, sif.busy, sif.done, sif.err);
        return 32'(o);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // downstream decoder gated by valid: exactly the expected line or nothing
    task automatic check_decoder(input exp_t want);
        logic [7:0] z, z_exp;
        z     = sif.valid ? (8'b1 << {sif.A2, sif.A1, sif.A0}) : 8'b0;
        z_exp = want.valid ? (8'b1 << want.code) : 8'b0;
        check_val("dec_onehot", 32'($countones(z) <= 1), 32'd1);
        check_val("dec_line", 32'(z), 32'(z_exp));
    endtask

    task automatic idle_check(input string tag);
        sif.start = 1'b0;
        sif.stop  = 1'($urandom_range(0, 1));
        sif.mask  = 8'($urandom);
        tick();
        check_val(tag, observed(), 32'(mk(model_code, 1'b0, 1'b0, 1'b0, 1'b0)));
        sif.stop = 1'b0;
    endtask

    // stop_at: cycle index after start at which stop is raised (-1: never)
    task automatic run_scan(input string tag, input logic [7:0] m, input logic os,
                            input int stop_at_in, input int max_cyc);
        exp_t q[$];
        logic [2:0] lc;
        int stop_at;
        bit stopped;
        lc = model_code;
        stop_at = stop_at_in;
        stopped = 1'b0;
        if (m == 8'h00) begin
            q.push_back(mk(lc, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            do begin
                for (int ch = 0; ch < 8; ch++) begin
                    q.push_back(mk(lc, 1'b0, 1'b1, 1'b0, 1'b0));
                    if (m[ch]) begin
                        lc = 3'(ch);
                        for (int k = 0; k < DWELL; k++) q.push_back(mk(lc, 1'b1, 1'b1, 1'b0, 1'b0));
                    end
                end
            end while (!os && q.size() < max_cyc);
            if (os) begin
                q.push_back(mk(lc, 1'b0, 1'b1, 1'b0, 1'b0));
                q.push_back(mk(lc, 1'b0, 1'b0, 1'b1, 1'b0));
            end else if (stop_at < 0 || stop_at >= q.size()) begin
                stop_at = q.size() - 1;
            end
        end

        sif.start    = 1'b1;
        sif.mask     = m;
        sif.one_shot = os;
        sif.stop     = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            tick();
            check_val(tag, observed(), 32'(q[i]));
            check_decoder(q[i]);
            model_code = q[i].code;
            if (q[i].busy) begin
                // busy: start, mask and one_shot must all be ignored
                sif.start    = 1'($urandom_range(0, 1));
                sif.mask     = 8'($urandom);
                sif.one_shot = 1'($urandom_range(0, 1));
                if (i == stop_at) begin
                    sif.stop = 1'b1;
                    tick();
                    check_val({tag, "_stop"}, observed(), 32'(mk(q[i].code, 1'b0, 1'b0, 1'b0, 1'b0)));
                    sif.stop  = 1'b0;
                    sif.start = 1'b0;
                    stopped   = 1'b1;
                    break;
                end
            end else begin
                sif.start = 1'b0;
            end
        end
        if (!os && m != 8'h00) check_val({tag, "_stopped"}, 32'(stopped), 32'd1);
        idle_check({tag, "_idle"});
    endtask

    initial begin
        sif.start = 1'b0; sif.stop = 1'b0; sif.one_shot = 1'b0; sif.mask = 8'h00;
        #3;
        check_val("reset_outputs", observed(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("post_reset_idle");

        run_scan("t2_all_oneshot", 8'hFF, 1'b1, -1, 0);
        run_scan("t3_ch1_ch7", 8'b1000_0010, 1'b1, -1, 0);
        run_scan("t4_ch0_loop", 8'h01, 1'b0, 40, 48);
        run_scan("t5_err", 8'h00, 1'b0, -1, 0);
        run_scan("t5_err_os", 8'h00, 1'b1, -1, 0);
        run_scan("stop_mid_oneshot", 8'b0101_1010, 1'b1, 9, 0);
        run_scan("ch7_only", 8'h80, 1'b1, -1, 0);

        // async reset mid-HOLD of channel 1
        sif.start = 1'b1; sif.mask = 8'hFF; sif.one_shot = 1'b1;
        tick();
        sif.start = 1'b0;
        repeat (7) tick();
        check_val("pre_rst_hold", observed(), 32'(mk(3'd1, 1'b1, 1'b1, 1'b0, 1'b0)));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst", observed(), 32'd0);
        model_code = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("post_async_rst_idle");

        for (int r = 0; r < 24; r++) begin
            logic [7:0] m;
            logic os;
            int sa;
            m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            os = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_scan("rand", m, os, sa, int'($urandom_range(20, 60)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "timeout");
    end
endmodule
